turbo_interleaver: RTL and testbench
====================================

# turbo_interleaver

Frame interleaver for the turbo encoder. Accepts the systematic bit stream, stores each frame in one half of a ping-pong buffer (row-wise), and replays it column-wise to the second constituent RSC encoder. Output pacing matches that encoder's one-bit-per-two-clocks consumption. It also supplies the encoder enable, which is dropped between frames so the trellis returns to state 0.

## Interface
- ROWS, 4, interleaver matrix rows (power of 2)
- COLS, 8, interleaver matrix columns (power of 2); frame length N = ROWS*COLS
- OUT_DIV, 2, clocks each output bit is held (matches constituent encoder rate)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- din  input  1  systematic input bit
- din_valid  input  1  din qualifier; bit accepted when din_valid && din_ready
- din_ready  output  1  high when a bank is free for writing
- dout  output  1  interleaved bit to constituent encoder x input
- dout_valid  output  1  dout qualifier, held OUT_DIV cycles per bit
- frame_start  output  1  one-cycle pulse on the first cycle of bit 0 of a frame
- enc_en  output  1  constituent encoder enable

## Operation
- Storage: two banks of N bits. wr_bank and rd_bank pointers. full[1:0] flags.
- Write side: linear address w = 0..N-1 into bank wr_bank. On accept of bit N-1:
  - set full[wr_bank];
  - toggle wr_bank;
  - clear w.
- din_ready = !full[wr_bank]. din_valid while din_ready=0 is ignored; no data is lost or stored.
- Read order: counter k = 0..N-1. col = k / ROWS, row = k % ROWS. Read address = row*COLS + col.
  - Example: the input bit at index i=r*COLS+c emerges at output position c*ROWS+r.
- Read FSM:
  - IDLE: when full[rd_bank] is set, go to READ and issue address k=0.
  - READ: present bit k for OUT_DIV cycles. After the last hold cycle of k=N-1:
    - clear full[rd_bank];
    - toggle rd_bank;
    - go to GAP.
  - GAP: exactly 1 cycle, with dout_valid=0 and enc_en=0. Then go to READ if full[rd_bank], else IDLE.
- Outputs:
  - enc_en=1 in READ only.
  - dout=0 whenever dout_valid=0.
- Simultaneous events:
  - Write completion and read completion may land on the same cycle, on different banks. Both flag updates take effect.
  - A bank cleared by the read side is writable on the next cycle (din_ready rises the cycle after the GAP entry edge).
- Reset (rst=1 at an edge) takes priority over everything and aborts any partial frame on either side:
  - w=0, k=0, wr_bank=0, rd_bank=0, full=00;
  - FSM=IDLE;
  - dout=0, dout_valid=0, frame_start=0, enc_en=0, din_ready=1 (first cycle after reset).

## Timing
- Write latency to output: accept of bit N-1 at edge E sets full. FSM enters READ at E+1. dout/dout_valid/frame_start/enc_en first high in the cycle after E+1 (2-clock latency, memory read registered).
- Within a frame:
  - dout_valid and enc_en are continuously high for N*OUT_DIV cycles.
  - dout changes only every OUT_DIV cycles, aligned to the start of frame_start.
  - This aligns with the encoder's internal phase starting at 0 after enable rises.
- Back-to-back frames: the last hold cycle of frame n is followed by exactly 1 GAP cycle. Frame n+1's frame_start occurs on the next cycle. No bubble beyond GAP.
- Throughput: input may stream 1 bit/clock. With both banks full, din_ready stays low until the current read frame completes.
- Bit ordering of dout within a frame is fully determined by k; no dependence on input timing gaps.

## Test plan
- Reset: hold rst 3 cycles mid-frame (after 10 bits written, none read) -> outputs as listed, din_ready=1, and no dout_valid until a fresh full frame of 32 bits is written.
- Permutation, single one (ROWS=4, COLS=8): frame with only i=1 set -> dout=1 only at output position 4; frame with only i=8 set -> dout=1 only at position 1; frame with only i=31 set -> position 31.
- Latency/pacing: write 32 bits contiguously ending at edge E -> frame_start high in the cycle after E+1; dout_valid high for 64 cycles; each bit stable for 2 cycles.
- Back-to-back: stream 3 frames at 1 bit/clock -> din_ready drops after frame 2; exactly one enc_en=0 cycle between output frames; all 96 bits are correct.
- Backpressure: drive din_valid=1 continuously while din_ready=0 -> ignored bits never appear; the frame-3 content equals the bits accepted after din_ready re-rises.
- Simultaneous complete: time the write of frame 2's last bit to coincide with frame 1's final hold cycle -> frame 2 output begins after exactly 1 GAP cycle, with full flags consistent (full=01 or 10, never 00).

Source files
------------

// File: rtl/turbo_interleaver.sv
// Ping-pong block interleaver for the turbo encoder: frames are written row-wise into
// one bank and replayed column-wise from the other, one bit per OUT_DIV clocks.
module turbo_interleaver #(
  parameter int ROWS    = 4,
  parameter int COLS    = 8,
  parameter int OUT_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic din_valid,
  output logic din_ready,
  output logic dout,
  output logic dout_valid,
  output logic frame_start,
  output logic enc_en
);
  // state | meaning
  // IDLE  | waiting for a full bank to replay
  // READ  | presenting bit k for OUT_DIV cycles, k walking the columns
  // GAP   | one idle cycle so the encoder trellis returns to state 0
  typedef enum logic [1:0] {IDLE, READ, GAP} state_t;

  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);
  localparam int RB = $clog2(ROWS);
  localparam int HW = (OUT_DIV > 1) ? $clog2(OUT_DIV) : 1;

  state_t          state, state_nxt;
  logic [N-1:0]    mem [2];
  logic [AW-1:0]   w, k, raddr;
  logic [HW-1:0]   h;
  logic            wr_bank, rd_bank;
  logic [1:0]      full, full_nxt;
  logic            wr_acc, wr_last, hold_last, rd_last;

  assign din_ready = !full[wr_bank];
  assign wr_acc    = din_valid && din_ready;
  assign wr_last   = wr_acc && (w == AW'(N - 1));
  assign hold_last = (h == HW'(OUT_DIV - 1));
  // k = col*ROWS + row, so swapping the two fields yields row*COLS + col
  assign raddr     = {k[RB-1:0], k[AW-1:RB]};

  always_comb begin
    state_nxt = state;
    rd_last   = 1'b0;
    case (state)
      IDLE: if (full[rd_bank]) state_nxt = READ;
      READ: begin
        if (hold_last && (k == AW'(N - 1))) begin
          rd_last   = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP:     state_nxt = full[rd_bank] ? READ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // write completion and read completion always hit different banks
  always_comb begin
    full_nxt = full;
    if (rd_last) full_nxt[rd_bank] = 1'b0;
    if (wr_last) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_bank][w] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w       <= '0;
      wr_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      full <= full_nxt;
      if (wr_acc) begin
        w <= wr_last ? '0 : w + 1'b1;
        if (wr_last) wr_bank <= ~wr_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k       <= '0;
      h       <= '0;
      rd_bank <= 1'b0;
    end else if (state == READ) begin
      if (hold_last) begin
        h <= '0;
        k <= rd_last ? '0 : k + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
      if (rd_last) rd_bank <= ~rd_bank;
    end
  end

  // registered memory read: outputs trail the FSM by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      dout        <= 1'b0;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      enc_en      <= 1'b0;
    end else begin
      dout_valid  <= (state == READ);
      enc_en      <= (state == READ);
      frame_start <= (state == READ) && (k == '0) && (h == '0);
      dout        <= (state == READ) ? mem[rd_bank][raddr] : 1'b0;
    end
  end
endmodule

// File: tb/tb_turbo_interleaver.sv
// Scoreboard bench for turbo_interleaver: expected column-wise bits are queued when a
// frame's last bit is accepted and compared hold-cycle by hold-cycle at the output.
module tb_turbo_interleaver;
  localparam int ROWS    = 4;
  localparam int COLS    = 8;
  localparam int OUT_DIV = 2;
  localparam int N       = ROWS * COLS;

  logic clk, rst, din, din_valid;
  logic din_ready, dout, dout_valid, frame_start, enc_en;

  turbo_interleaver #(.ROWS(ROWS), .COLS(COLS), .OUT_DIV(OUT_DIV)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .frame_start(frame_start), .enc_en(enc_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk = 0, n_pass = 0;
  int   cyc = 0;
  logic exp_q[$];
  int   gaps[$];
  int   run = 0, gap = 1000, fs_cyc = 0;
  logic cur = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // output monitor
  initial forever begin
    @(negedge clk);
    if (rst) begin
      run = 0;
      gap = 1000;
    end else begin
      chk("enc_en", enc_en, dout_valid);
      if (dout_valid) begin
        if (run == 0) begin
          gaps.push_back(gap);
          gap    = 0;
          fs_cyc = cyc;
          chk("frame_start", frame_start, 1);
        end else begin
          chk("frame_start", frame_start, 0);
        end
        if (run % OUT_DIV == 0) begin
          if (exp_q.size() == 0) begin
            chk("spurious_valid", dout_valid, 0);
            cur = 1'b0;
          end else begin
            cur = exp_q.pop_front();
          end
        end
        chk("dout", dout, cur);
        run++;
      end else begin
        chk("dout_idle", dout, 0);
        chk("frame_start_idle", frame_start, 0);
        if (run != 0) chk("run_len", run, N * OUT_DIV);
        run = 0;
        if (gap < 1000) gap++;
      end
    end
  end

  // input index r*COLS+c leaves at output position c*ROWS+r
  function automatic logic [N-1:0] permute(input logic [N-1:0] in);
    logic [N-1:0] o;
    o = '0;
    for (int i = 0; i < N; i++) o[(i % COLS) * ROWS + (i / COLS)] = in[i];
    return o;
  endfunction

  // called and returns at a negedge; last_at holds back the final bit until cyc==last_at
  task automatic put_frame(input logic [N-1:0] bits, input int last_at,
                           output int e_cyc, output int stalls);
    int   idx, guard;
    logic acc;
    logic [N-1:0] o;
    idx = 0; guard = 0; stalls = 0;
    while (idx < N && guard < 5000) begin
      acc = 1'b0;
      if (idx == N - 1 && cyc < last_at) begin
        din_valid = 1'b0;
      end else if (din_ready) begin
        din = bits[idx]; din_valid = 1'b1; acc = 1'b1;
      end else begin
        din = ~bits[idx]; din_valid = 1'b1; stalls++;
      end
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
      guard++;
    end
    din_valid = 1'b0;
    din = 1'b0;
    chk("frame_accepted", idx, N);
    if (idx == N) begin
      o = permute(bits);
      for (int p = 0; p < N; p++) exp_q.push_back(o[p]);
    end
    e_cyc = cyc;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !dout_valid && run == 0) break;
    end
    chk("drain_queue", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_din_ready", din_ready, 1);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_enc_en", enc_en, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_dout", dout, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e, s, e2, s2, e3, s3, ea, eb;
    logic [N-1:0] f;
    rst = 1'b1; din = 1'b0; din_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // single-one permutation frames, latency on the first
    f = '0; f[1] = 1'b1;
    put_frame(f, -1, e, s);
    wait_idle();
    chk("latency", fs_cyc - e, 2);
    f = '0; f[8] = 1'b1;
    put_frame(f, -1, e, s);
    wait_idle();
    f = '0; f[31] = 1'b1;
    put_frame(f, -1, e, s);
    wait_idle();
    chk("latency_f31", fs_cyc - e, 2);

    // mid-frame reset: 10 bits written, then rst for 3 cycles
    for (int i = 0; i < 10; i++) begin
      din = 1'($urandom_range(0, 1)); din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    f = N'($urandom());
    put_frame(f, cyc + 100, e, s);
    wait_idle();

    // three frames streamed at one bit per clock
    gaps.delete();
    put_frame(N'($urandom()), -1, e, s);
    put_frame(N'($urandom()), -1, e2, s2);
    put_frame(N'($urandom()), -1, e3, s3);
    chk("f2_no_stall", s2, 0);
    chk("f3_stalled", (s3 > 0) ? 1 : 0, 1);
    wait_idle();
    if (gaps.size() != 3) chk("b2b_runs", gaps.size(), 3);
    else begin
      chk("b2b_gap1", gaps[1], 1);
      chk("b2b_gap2", gaps[2], 1);
    end

    // write of frame B's last bit on frame A's final hold cycle
    gaps.delete();
    put_frame(N'($urandom()), -1, ea, s);
    put_frame(N'($urandom()), ea + 64, eb, s);
    chk("sim_align", eb - ea, 65);
    chk("sim_ready_after", din_ready, 1);
    wait_idle();
    if (gaps.size() != 2) chk("sim_runs", gaps.size(), 2);
    else chk("sim_gap", gaps[1], 1);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
